int8_skew_feeder: RTL and testbench
===================================

INT8_SKEW_FEEDER -- requirements
Module: int8_skew_feeder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of systolic lanes (1..16).
REQ-002 The block SHALL have parameter W, default 8, giving the signed element width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  feeder can accept a beat.
REQ-007 in_data  input  N*W  one unskewed vector; element i at bits [i*W +: W], signed.
REQ-008 in_last  input  1  final beat of the current operand stream.
REQ-009 out_data  output  N*W  skewed lane values driven to array edge inputs (MAC inA/inB), signed.
REQ-010 out_valid  output  N  per-lane flag: out_data lane i carries real data, not padding.
REQ-011 done  output  1  one-cycle pulse when the stream has fully left the feeder.

Function
REQ-012 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-013 Element i of a beat accepted at edge t SHALL appear on out_data lane i after edge t+1+i, with out_valid[i]=1, for exactly one cycle.
REQ-014 Each lane SHALL be a shift chain of depth i+1 that advances every cycle; the feeder never stalls, as the array has no backpressure.
REQ-015 On a cycle with no accepted beat, lane-0 input SHALL be zero with valid 0; these bubbles propagate skewed exactly like data.
REQ-016 Lanes with out_valid[i]=0 SHALL drive out_data lane i = 0, so downstream MACs accumulate zero.
REQ-017 The state machine SHALL have states IDLE, STREAM, DRAIN and DONE.
REQ-018 IDLE: in_ready=1. An accepted beat with in_last=0 goes to STREAM. An accepted beat with in_last=1 goes to DRAIN if N>1, otherwise to DONE.
REQ-019 STREAM: in_ready=1. An accepted beat with in_last=1 goes to DRAIN (N>1) or DONE (N=1). Bubbles keep the state at STREAM.
REQ-020 DRAIN: in_ready=0. A counter loads N-1 on entry and decrements each cycle; at 1 it goes to DONE.
REQ-021 DONE: in_ready=0, done=1 for exactly one cycle, then IDLE. done is asserted in the cycle lane N-1 shows the last beat's element.
REQ-022 With the beat counter feature compiled in, the counter SHALL wrap from 2^16-1 to 0 without flagging.

Reset
REQ-023 While reset=0, all shift stages SHALL be 0, out_data=0, out_valid=0, done=0, in_ready=0 and state=IDLE.
REQ-024 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-STREAM or mid-DRAIN SHALL discard all in-flight data immediately, with no done pulse.

Configuration
REQ-026 The macro INT8_SKEW_FEEDER_BEAT_CNT_EN SHALL control the beat counter.
REQ-027 When INT8_SKEW_FEEDER_BEAT_CNT_EN is defined, the block SHALL add output beat_cnt (16 bits), counting accepted beats since the last DONE; it resets to 0 and clears on leaving DONE.
REQ-028 Without INT8_SKEW_FEEDER_BEAT_CNT_EN, the beat_cnt port and counter SHALL be absent, with identical other behaviour.

Structure
REQ-029 The shared package systolic_pkg SHALL hold the state enum feeder_state_t and the constant ELEM_W=8 used by W's default.
REQ-030 One sub-module, skew_delay_line (parameter DEPTH, data plus valid), SHALL implement each lane, instantiated N times via generate.

Verification
REQ-031 N=4, single beat {4,3,2,1} with last in IDLE -> lane0=1 @t+1, lane1=2 @t+2, lane2=3 @t+3, lane3=4 @t+4; done @t+4; in_ready low for t+1..t+4.
REQ-032 N=4, 3 back-to-back beats, last on third -> each lane shows 3 consecutive valid values in order; done exactly once, 3 cycles after the last accept plus 1.
REQ-033 N=4, beat, 2 bubble cycles, beat with last -> each lane shows data, 0/0, 0/0, data; never non-zero data with valid 0.
REQ-034 in_valid held high through DRAIN -> no acceptance while in_ready=0; the next beat is accepted only after returning to IDLE.
REQ-035 Reset pulsed mid-DRAIN -> out_data=0, out_valid=0 asynchronously; no done; in_ready=1 the cycle after release.
REQ-036 With INT8_SKEW_FEEDER_BEAT_CNT_EN, 5 beats -> beat_cnt=5 at DONE, 0 in the following IDLE; signed value -128 on lane 2 is passed through unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array edge feeders: element width,
// counter widths and the skew feeder state encoding.
package systolic_pkg;

    // Default signed element width of one systolic lane.
    localparam int ELEM_W = 8;

    // Width of the optional accepted-beat counter.
    localparam int BEAT_CNT_W = 16;

    // Drain counter width; holds N-1 for any lane count up to 16.
    localparam int DRAIN_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    // Number of drain cycles after the final beat: the deepest lane needs
    // lanes-1 further edges before its last element is on the output.
    function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int lanes);
        return DRAIN_CNT_W'(lanes - 1);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One feeder lane: a DEPTH-stage data+valid shift chain that advances on
// every clock. Bubbles enter as zero data with valid low, and the output is
// forced to zero whenever the emerging stage is not valid.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] data_q;
            logic         valid_q;

            if (gi == 0) begin : g_head
                // First stage captures the incoming element, or a zero bubble.
                always_ff @(posedge clk or negedge rst_ni) begin
                    if (!rst_ni) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= valid_i ? data_i : '0;
                        valid_q <= valid_i;
                    end
                end
            end else begin : g_tail
                // Later stages simply shift the previous stage along.
                always_ff @(posedge clk or negedge rst_ni) begin
                    if (!rst_ni) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= g_stage[gi-1].data_q;
                        valid_q <= g_stage[gi-1].valid_q;
                    end
                end
            end
        end
    endgenerate

    assign valid_o = g_stage[DEPTH-1].valid_q;
    assign data_o  = g_stage[DEPTH-1].valid_q ? g_stage[DEPTH-1].data_q : '0;

endmodule

// File: rtl/int8_skew_feeder.sv
// Skew feeder for a systolic array edge: each accepted vector is split into
// N lanes, lane i delayed by i+1 cycles so elements arrive diagonally.
// A small FSM closes each operand stream and pulses done when the last
// element has left the deepest lane.
// Optional feature: define INT8_SKEW_FEEDER_BEAT_CNT_EN to add the 16-bit
// beat_cnt output (accepted beats since the last DONE, wrapping silently).
module int8_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ELEM_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_last,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_valid,
    output logic           done
`ifdef INT8_SKEW_FEEDER_BEAT_CNT_EN
    ,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    feeder_state_t          state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   accept;

    assign accept = in_valid & in_ready;

    // State register and drain counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic: a last beat skips DRAIN when there is only one lane.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE, STREAM: begin
                if (accept && in_last) begin
                    if (N > 1) begin
                        state_d     = DRAIN;
                        drain_cnt_d = drain_load(N);
                    end else begin
                        state_d = DONE;
                    end
                end else if (accept) begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: ready only while taking a stream and never while held in reset.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, STREAM: in_ready = reset;
            DONE:         done     = 1'b1;
            default:      ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            skew_delay_line #(
                .DEPTH(gi + 1),
                .W    (W)
            ) u_lane (
                .clk    (clk),
                .rst_ni (reset),
                .data_i (in_data[gi*W +: W]),
                .valid_i(accept),
                .data_o (out_data[gi*W +: W]),
                .valid_o(out_valid[gi])
            );
        end
    endgenerate

`ifdef INT8_SKEW_FEEDER_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Beat count clears on the way out of DONE; no accept can occur in DONE.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == DONE) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_int8_skew_feeder.sv
// Scoreboard bench for int8_skew_feeder (N=4, W=8). A reference model pushes
// the expected appearance cycle of every element, plus done cycles, into
// queues; an independent monitor pops and compares on each falling edge.
module tb_int8_skew_feeder;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_last;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic           done;
`ifdef INT8_SKEW_FEEDER_BEAT_CNT_EN
    logic [15:0]    beat_cnt;
`endif

    always #5 clk = ~clk;

    int8_skew_feeder #(.N(N), .W(W)) dut (
`ifdef INT8_SKEW_FEEDER_BEAT_CNT_EN
        .beat_cnt (beat_cnt),
`endif
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_data (out_data),
        .out_valid(out_valid),
        .done     (done)
    );

    typedef struct {
        logic signed [W-1:0] d;
        int                  c;
    } exp_t;

    exp_t lane_q[N][$];
    int   done_q[$];
    int   cyc        = 0;
    int   busy_until = 0;
    int   last_done  = -1;
    int   exp_cnt    = 0;
    int   n_cmp      = 0;
    int   n_err      = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    // Reference model: a beat is taken when the feeder is not busy finishing
    // a stream; element i of a beat taken at edge k shows at cycle k+i, and
    // the final beat's done shows at cycle k+N-1, after which the feeder is
    // free again from cycle k+N.
    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = (reset === 1'b1) && in_valid && (cyc >= busy_until);
            if (cyc == last_done) exp_cnt = 0;
            cyc = cyc + 1;
            if (acc) begin
                exp_cnt = exp_cnt + 1;
                for (int i = 0; i < N; i++) begin
                    e.d = in_data[i*W +: W];
                    e.c = cyc + i;
                    lane_q[i].push_back(e);
                end
                if (in_last) begin
                    done_q.push_back(cyc + N - 1);
                    busy_until = cyc + N;
                    last_done  = cyc + N - 1;
                end
                $display("beat  cycle %0d data %h last %0b", cyc, in_data, in_last);
            end
        end
    end

    // Monitor: compares every lane, ready, done and the optional count.
    initial begin
        exp_t e;
        int   dc;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("in_ready", in_ready, cyc >= busy_until);
                for (int i = 0; i < N; i++) begin
                    if (out_valid[i]) begin
                        if (lane_q[i].size() == 0) begin
                            check($sformatf("lane%0d_spurious_valid", i), 1, 0);
                        end else begin
                            e = lane_q[i].pop_front();
                            check($sformatf("lane%0d_cycle", i), cyc, e.c);
                            check($sformatf("lane%0d_data", i), $signed(out_data[i*W +: W]), e.d);
                        end
                    end else begin
                        check($sformatf("lane%0d_pad_zero", i), out_data[i*W +: W], 0);
                        if (lane_q[i].size() != 0 && lane_q[i][0].c <= cyc) begin
                            check($sformatf("lane%0d_missing_valid", i), 0, 1);
                            e = lane_q[i].pop_front();
                        end
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("done_spurious", 1, 0);
                    end else begin
                        dc = done_q.pop_front();
                        check("done_cycle", cyc, dc);
                        $display("done  cycle %0d", cyc);
                    end
                end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                    check("done_missing", 0, 1);
                    dc = done_q.pop_front();
                end
`ifdef INT8_SKEW_FEEDER_BEAT_CNT_EN
                check("beat_cnt", beat_cnt, exp_cnt & 32'hFFFF);
`endif
            end
        end
    end

    task automatic drive(input logic [N*W-1:0] d, input logic v, input logic l);
        @(negedge clk);
        in_data  = d;
        in_valid = v;
        in_last  = l;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (cyc < busy_until) begin
            @(negedge clk);
            n++;
            if (n > bound) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] d;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Single final beat from IDLE.
        drive({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b1);
        idle();
        wait_idle(40);

        // Three back-to-back beats, last on the third.
        drive({8'd13, 8'd12, 8'd11, 8'd10}, 1'b1, 1'b0);
        drive({8'd23, 8'd22, 8'd21, 8'd20}, 1'b1, 1'b0);
        drive({8'd33, 8'd32, 8'd31, 8'd30}, 1'b1, 1'b1);
        idle();
        wait_idle(40);

        // Beat, two bubbles, final beat.
        drive({8'h44, 8'h43, 8'h42, 8'h41}, 1'b1, 1'b0);
        idle();
        idle();
        drive({8'h54, 8'h53, 8'h52, 8'h51}, 1'b1, 1'b1);
        idle();
        wait_idle(40);

        // in_valid held high through DRAIN/DONE: only ready cycles accept.
        for (int b = 0; b < 20; b++) drive(rand_vec(), 1'b1, 1'b1);
        idle();
        wait_idle(40);

        // Five beats with -128 on lane 2.
        for (int b = 0; b < 5; b++) begin
            d = rand_vec();
            d[2*W +: W] = 8'h80;
            drive(d, 1'b1, b == 4);
        end
        idle();
        wait_idle(40);

        // Random traffic.
        for (int b = 0; b < 400; b++) begin
            drive(rand_vec(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        drive(rand_vec(), 1'b1, 1'b1);
        idle();
        wait_idle(40);

        // Reset pulsed while draining: everything in flight is discarded.
        drive({8'h7F, 8'h80, 8'h01, 8'hFF}, 1'b1, 1'b1);
        idle();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_out_data", out_data, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_in_ready", in_ready, 0);
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        busy_until = 0;
        last_done  = -1;
        exp_cnt    = 0;
        $display("reset cycle %0d", cyc);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Normal operation resumes after the release.
        drive({8'h04, 8'hFC, 8'h02, 8'hFE}, 1'b1, 1'b1);
        idle();
        wait_idle(40);
        repeat (N + 2) @(negedge clk);

        for (int i = 0; i < N; i++) check($sformatf("lane%0d_leftover", i), lane_q[i].size(), 0);
        check("done_leftover", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog at cycle %0d: got timeout, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
